wishbone_bus_if: RTL and testbench
==================================

# wishbone_bus_if

Wishbone B4 classic master bridge between the core's data-memory port (`ram_*` signals) and an external Wishbone bus. It converts the core's single-cycle, combinational-read memory interface into multi-cycle bus transactions. While a transaction is outstanding it raises a stop request into `ctrl`, so the pipeline freezes until the slave acknowledges. It holds read data until the pipeline has actually advanced past MEM, which makes the core tolerant of variable slave latency.

## Interface
- Parameters: none. Widths come from the shared `defines.v` (`RegisterBus` = 32 bits, `StopAllBus` = 6 bits).
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clock` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `stop_all` input 6: current stall vector from `ctrl`.
- `flush` input 1: discard any in-flight access.
- `cpu_chip_enable_input` input 1: core requests an access.
- `cpu_address_input` input 32: byte address.
- `cpu_data_input` input 32: store data.
- `cpu_write_enable_input` input 1: 1 = store, 0 = load.
- `cpu_sel_input` input 4: byte lanes.
- `cpu_data_output` output 32: load data to MEM stage.
- `stop_req_output` output 1: stall request to `ctrl`.
- `wishbone_data_input` input 32: slave read data.
- `wishbone_ack_input` input 1: slave acknowledge.
- `wishbone_address_output` output 32: bus address.
- `wishbone_data_output` output 32: bus write data.
- `wishbone_write_enable_output` output 1: WE.
- `wishbone_sel_output` output 4: SEL.
- `wishbone_strobe_output` output 1: STB.
- `wishbone_cycle_output` output 1: CYC.

## Operation
- State register with three states: IDLE, BUSY, WAIT_FOR_STALL. The bus outputs and the 32-bit `read_buffer` are registered.
- **IDLE**
  - If `cpu_chip_enable_input && !flush`: latch address, data, WE and SEL onto the bus outputs, set CYC = STB = 1, clear `read_buffer`, and go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - If `flush`: drive all bus outputs to 0, clear `read_buffer`, and go to IDLE. Flush has priority over ack.
  - Else if `wishbone_ack_input`: drive all bus outputs to 0. On a read, capture `wishbone_data_input` into `read_buffer`. Then go to WAIT_FOR_STALL if `stop_all != 0`, otherwise go to IDLE.
  - Else hold the bus outputs stable (Wishbone rule: no change while STB is high and ack is low).
- **WAIT_FOR_STALL**
  - If `flush`: clear `read_buffer` and go to IDLE.
  - Else if `stop_all == 0`: go to IDLE.
  - Otherwise stay.
- `stop_req_output` and `cpu_data_output` are combinational:
  - IDLE: `stop_req_output = cpu_chip_enable_input && !flush`; `cpu_data_output = 0`.
  - BUSY with ack and no flush: `stop_req_output = 0`; `cpu_data_output = wishbone_data_input` on a read, 0 on a write.
  - BUSY without ack: `stop_req_output = !flush`; `cpu_data_output = 0`.
  - WAIT_FOR_STALL: `stop_req_output = 0`; `cpu_data_output = read_buffer`.
- Reset forces IDLE, all registered outputs to 0 and `read_buffer` to 0, regardless of the current state. A bus cycle in progress is dropped: CYC falls on the next edge.

## Timing
- Request seen in IDLE at cycle 0: `stop_req_output` is 1 in cycle 0, and CYC/STB are high from cycle 1.
- Ack arriving in cycle k (k ≥ 1):
  - The pipeline advances at the end of cycle k.
  - CYC/STB fall in cycle k+1.
  - A new request is accepted in IDLE no earlier than cycle k+1.
- Minimum access time is 2 cycles, with ack in cycle 1. No back-to-back STB without a CYC gap.
- Data in WAIT_FOR_STALL stays stable until `stop_all` clears.

## Structure
- State encodings `WB_IDLE = 2'b00`, `WB_BUSY = 2'b01`, `WB_WAIT_FOR_STALL = 2'b10` are added to `defines.v`.
- One module, no sub-modules.
- Instantiation: one instance is placed between the `ram_*` ports and the bus, and a second identical instance goes on the `rom_*` port. `ctrl` gains a `stop_all_req_from_if`/`_from_mem` input driven by `stop_req_output`.

## Test plan
- Read at `0x100`, ack in cycle 3 with data `0xDEADBEEF`:
  - `stop_req_output` is 1 in cycles 0–2 and 0 in cycle 3.
  - `cpu_data_output = 0xDEADBEEF` in cycle 3.
  - CYC = 0 in cycle 4.
- Write `0x12345678` to `0x200` with SEL `4'b0011`, ack in cycle 1: the bus carries exactly those values in cycle 1, WE = 1, `cpu_data_output = 0`, and the block returns to IDLE.
- Read acked in cycle 2 while `stop_all = 6'b000011`, with `stop_all` clearing in cycle 5:
  - State is WAIT_FOR_STALL in cycles 3–5.
  - `cpu_data_output` holds the acked data.
  - `stop_req_output` stays 0.
- Flush asserted in BUSY together with ack: outputs are zeroed, nothing is captured, the next state is IDLE and `stop_req_output = 0`.
- Slave withholds ack for 10 cycles: address, data, SEL and WE stay constant and STB stays 1 throughout.
- Reset pulsed during BUSY: the next cycle shows all outputs at 0 and state IDLE, and a later read completes normally.

Source files
------------

// File: rtl/wishbone_bus_if_pkg.sv
// Shared types for the Wishbone classic master bridge: state encoding and bus request bundle.
package wishbone_bus_if_pkg;

    localparam int REG_W      = 32;
    localparam int STOP_ALL_W = 6;
    localparam int SEL_W      = 4;

    typedef enum logic [1:0] {
        WB_IDLE           = 2'b00,
        WB_BUSY           = 2'b01,
        WB_WAIT_FOR_STALL = 2'b10
    } wb_state_e;

    typedef struct packed {
        logic [REG_W-1:0] addr;
        logic [REG_W-1:0] data;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic             cyc;
        logic             stb;
    } wb_bus_t;

    function automatic wb_bus_t wb_bus_idle();
        wb_bus_t b;
        b = '0;
        return b;
    endfunction

endpackage

// File: rtl/wishbone_bus_if.sv
// Wishbone B4 classic master bridge for the core's single-cycle memory port.
// Stalls the pipeline while a cycle is open and holds read data until the stall lifts.
module wishbone_bus_if
    import wishbone_bus_if_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STOP_ALL_W-1:0] stop_all,
    input  logic                  flush,
    input  logic                  cpu_chip_enable_input,
    input  logic [REG_W-1:0]      cpu_address_input,
    input  logic [REG_W-1:0]      cpu_data_input,
    input  logic                  cpu_write_enable_input,
    input  logic [SEL_W-1:0]      cpu_sel_input,
    output logic [REG_W-1:0]      cpu_data_output,
    output logic                  stop_req_output,
    input  logic [REG_W-1:0]      wishbone_data_input,
    input  logic                  wishbone_ack_input,
    output logic [REG_W-1:0]      wishbone_address_output,
    output logic [REG_W-1:0]      wishbone_data_output,
    output logic                  wishbone_write_enable_output,
    output logic [SEL_W-1:0]      wishbone_sel_output,
    output logic                  wishbone_strobe_output,
    output logic                  wishbone_cycle_output
);

    wb_state_e        state_q, state_d;
    wb_bus_t          bus_q, bus_d;
    logic [REG_W-1:0] read_buffer_q, read_buffer_d;

    always_comb begin
        state_d         = state_q;
        bus_d           = bus_q;
        read_buffer_d   = read_buffer_q;
        stop_req_output = 1'b0;
        cpu_data_output = '0;

        case (state_q)
            WB_IDLE: begin
                if (cpu_chip_enable_input && !flush) begin
                    bus_d.addr      = cpu_address_input;
                    bus_d.data      = cpu_data_input;
                    bus_d.we        = cpu_write_enable_input;
                    bus_d.sel       = cpu_sel_input;
                    bus_d.cyc       = 1'b1;
                    bus_d.stb       = 1'b1;
                    read_buffer_d   = '0;
                    stop_req_output = 1'b1;
                    state_d         = WB_BUSY;
                end
            end
            WB_BUSY: begin
                if (flush) begin
                    bus_d         = wb_bus_idle();
                    read_buffer_d = '0;
                    state_d       = WB_IDLE;
                end else if (wishbone_ack_input) begin
                    bus_d = wb_bus_idle();
                    if (!bus_q.we) begin
                        read_buffer_d   = wishbone_data_input;
                        cpu_data_output = wishbone_data_input;
                    end
                    // MEM still stalled by someone else: park the data until it advances
                    state_d = (stop_all != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
                end else begin
                    stop_req_output = 1'b1;
                end
            end
            WB_WAIT_FOR_STALL: begin
                cpu_data_output = read_buffer_q;
                if (flush) begin
                    read_buffer_d = '0;
                    state_d       = WB_IDLE;
                end else if (stop_all == '0) begin
                    state_d = WB_IDLE;
                end
            end
            default: begin
                bus_d   = wb_bus_idle();
                state_d = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= WB_IDLE;
            bus_q         <= wb_bus_idle();
            read_buffer_q <= '0;
        end else begin
            state_q       <= state_d;
            bus_q         <= bus_d;
            read_buffer_q <= read_buffer_d;
        end
    end

    assign wishbone_address_output      = bus_q.addr;
    assign wishbone_data_output         = bus_q.data;
    assign wishbone_write_enable_output = bus_q.we;
    assign wishbone_sel_output          = bus_q.sel;
    assign wishbone_strobe_output       = bus_q.stb;
    assign wishbone_cycle_output        = bus_q.cyc;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if: inputs change 1ns after posedge, outputs sampled 3ns later.
module tb_wishbone_bus_if;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  stop_all;
    logic        flush;
    logic        ce;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_rdata;
    logic        stop_req;
    logic [31:0] wb_din;
    logic        wb_ack;
    logic [31:0] wb_adr;
    logic [31:0] wb_dout;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    wishbone_bus_if dut (
        .clock                        (clock),
        .reset                        (reset),
        .stop_all                     (stop_all),
        .flush                        (flush),
        .cpu_chip_enable_input        (ce),
        .cpu_address_input            (cpu_addr),
        .cpu_data_input               (cpu_wdata),
        .cpu_write_enable_input       (cpu_we),
        .cpu_sel_input                (cpu_sel),
        .cpu_data_output              (cpu_rdata),
        .stop_req_output              (stop_req),
        .wishbone_data_input          (wb_din),
        .wishbone_ack_input           (wb_ack),
        .wishbone_address_output      (wb_adr),
        .wishbone_data_output         (wb_dout),
        .wishbone_write_enable_output (wb_we),
        .wishbone_sel_output          (wb_sel),
        .wishbone_strobe_output       (wb_stb),
        .wishbone_cycle_output        (wb_cyc)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic check_bus_idle(input string tag);
        check_eq({tag, "_cyc"}, {31'd0, wb_cyc}, 32'd0);
        check_eq({tag, "_stb"}, {31'd0, wb_stb}, 32'd0);
        check_eq({tag, "_adr"}, wb_adr, 32'd0);
        check_eq({tag, "_dat"}, wb_dout, 32'd0);
        check_eq({tag, "_we"}, {31'd0, wb_we}, 32'd0);
        check_eq({tag, "_sel"}, {28'd0, wb_sel}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; stop_all = '0; flush = 1'b0; ce = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_sel = '0;
        wb_din = '0; wb_ack = 1'b0;
        step(); step();
        reset = 1'b0;
        settle();
        check_bus_idle("rst");
        check_eq("rst_stopreq", {31'd0, stop_req}, 32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'd0);

        // Read at 0x100, ack in cycle 3
        step();
        ce = 1'b1; cpu_addr = 32'h100; cpu_we = 1'b0; cpu_sel = 4'hF;
        settle();
        check_eq("rd_c0_stopreq", {31'd0, stop_req}, 32'd1);
        check_eq("rd_c0_cyc", {31'd0, wb_cyc}, 32'd0);
        step(); settle();
        check_eq("rd_c1_stopreq", {31'd0, stop_req}, 32'd1);
        check_eq("rd_c1_cyc", {31'd0, wb_cyc}, 32'd1);
        check_eq("rd_c1_stb", {31'd0, wb_stb}, 32'd1);
        check_eq("rd_c1_adr", wb_adr, 32'h100);
        check_eq("rd_c1_we", {31'd0, wb_we}, 32'd0);
        step(); settle();
        check_eq("rd_c2_stopreq", {31'd0, stop_req}, 32'd1);
        step();
        wb_ack = 1'b1; wb_din = 32'hDEADBEEF; ce = 1'b0;
        settle();
        check_eq("rd_c3_stopreq", {31'd0, stop_req}, 32'd0);
        check_eq("rd_c3_rdata", cpu_rdata, 32'hDEADBEEF);
        step();
        wb_ack = 1'b0; wb_din = '0;
        settle();
        check_bus_idle("rd_c4");
        check_eq("rd_c4_rdata", cpu_rdata, 32'd0);

        // Write 0x12345678 to 0x200, SEL 0011, ack in cycle 1
        step();
        ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'h12345678; cpu_sel = 4'b0011;
        settle();
        check_eq("wr_c0_stopreq", {31'd0, stop_req}, 32'd1);
        step();
        ce = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_sel = '0;
        wb_ack = 1'b1; wb_din = 32'h55555555;
        settle();
        check_eq("wr_c1_adr", wb_adr, 32'h200);
        check_eq("wr_c1_dat", wb_dout, 32'h12345678);
        check_eq("wr_c1_sel", {28'd0, wb_sel}, 32'h3);
        check_eq("wr_c1_we", {31'd0, wb_we}, 32'd1);
        check_eq("wr_c1_cyc", {31'd0, wb_cyc}, 32'd1);
        check_eq("wr_c1_rdata", cpu_rdata, 32'd0);
        check_eq("wr_c1_stopreq", {31'd0, stop_req}, 32'd0);
        step();
        wb_ack = 1'b0; wb_din = '0;
        settle();
        check_bus_idle("wr_c2");
        check_eq("wr_c2_stopreq", {31'd0, stop_req}, 32'd0);

        // Read acked in cycle 2 under stall; stall clears in cycle 5
        step();
        ce = 1'b1; cpu_addr = 32'h300; cpu_sel = 4'hF;
        settle();
        step(); settle();
        check_eq("st_c1_cyc", {31'd0, wb_cyc}, 32'd1);
        step();
        wb_ack = 1'b1; wb_din = 32'hCAFEF00D; stop_all = 6'b000011;
        settle();
        check_eq("st_c2_rdata", cpu_rdata, 32'hCAFEF00D);
        check_eq("st_c2_stopreq", {31'd0, stop_req}, 32'd0);
        for (int c = 3; c <= 5; c++) begin
            step();
            wb_ack = 1'b0; wb_din = 32'h99999999;
            if (c == 5) stop_all = '0;
            settle();
            // ce still high: an IDLE bridge would request a stall and show zero data
            check_eq($sformatf("st_c%0d_rdata", c), cpu_rdata, 32'hCAFEF00D);
            check_eq($sformatf("st_c%0d_stopreq", c), {31'd0, stop_req}, 32'd0);
            check_eq($sformatf("st_c%0d_cyc", c), {31'd0, wb_cyc}, 32'd0);
        end
        step();
        ce = 1'b0; wb_din = '0;
        settle();
        check_eq("st_c6_rdata", cpu_rdata, 32'd0);
        check_eq("st_c6_stopreq", {31'd0, stop_req}, 32'd0);

        // Flush together with ack in BUSY
        step();
        ce = 1'b1; cpu_addr = 32'h400;
        settle();
        step();
        ce = 1'b0; flush = 1'b1; wb_ack = 1'b1; wb_din = 32'h11112222; stop_all = 6'b000011;
        settle();
        check_eq("fl_c1_stopreq", {31'd0, stop_req}, 32'd0);
        check_eq("fl_c1_rdata", cpu_rdata, 32'd0);
        step();
        flush = 1'b0; wb_ack = 1'b0; wb_din = '0;
        settle();
        check_bus_idle("fl_c2");
        check_eq("fl_c2_rdata", cpu_rdata, 32'd0);
        check_eq("fl_c2_stopreq", {31'd0, stop_req}, 32'd0);
        step();
        stop_all = '0;
        settle();

        // Slave withholds ack for 10 cycles
        step();
        ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h500; cpu_wdata = 32'hA5A5A5A5; cpu_sel = 4'b1100;
        settle();
        for (int c = 1; c <= 10; c++) begin
            step();
            cpu_addr = 32'hF000_0000 + c; cpu_wdata = ~cpu_wdata; cpu_we = c[0]; cpu_sel = c[3:0];
            settle();
            check_eq($sformatf("hold_c%0d_adr", c), wb_adr, 32'h500);
            check_eq($sformatf("hold_c%0d_dat", c), wb_dout, 32'hA5A5A5A5);
            check_eq($sformatf("hold_c%0d_sel", c), {28'd0, wb_sel}, 32'hC);
            check_eq($sformatf("hold_c%0d_we", c), {31'd0, wb_we}, 32'd1);
            check_eq($sformatf("hold_c%0d_stb", c), {31'd0, wb_stb}, 32'd1);
            check_eq($sformatf("hold_c%0d_stopreq", c), {31'd0, stop_req}, 32'd1);
        end
        step();
        ce = 1'b0; cpu_we = 1'b0; wb_ack = 1'b1;
        settle();
        check_eq("hold_ack_stopreq", {31'd0, stop_req}, 32'd0);
        step();
        wb_ack = 1'b0;
        settle();
        check_bus_idle("hold_end");

        // Reset pulsed during BUSY, then a normal read
        step();
        ce = 1'b1; cpu_addr = 32'h600; cpu_sel = 4'hF;
        settle();
        step();
        ce = 1'b0; reset = 1'b1;
        settle();
        check_eq("rb_c1_cyc", {31'd0, wb_cyc}, 32'd1);
        step();
        reset = 1'b0;
        settle();
        check_bus_idle("rb_c2");
        check_eq("rb_c2_stopreq", {31'd0, stop_req}, 32'd0);
        check_eq("rb_c2_rdata", cpu_rdata, 32'd0);
        step();
        ce = 1'b1; cpu_addr = 32'h700;
        settle();
        check_eq("rb_rd_c0_stopreq", {31'd0, stop_req}, 32'd1);
        step();
        ce = 1'b0; wb_ack = 1'b1; wb_din = 32'h0BADF00D;
        settle();
        check_eq("rb_rd_c1_adr", wb_adr, 32'h700);
        check_eq("rb_rd_c1_rdata", cpu_rdata, 32'h0BADF00D);
        check_eq("rb_rd_c1_stopreq", {31'd0, stop_req}, 32'd0);
        step();
        wb_ack = 1'b0; wb_din = '0;
        settle();
        check_bus_idle("rb_rd_c2");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
